sdram_bridge_arbiter: RTL
=========================

// Module: sdram_bridge_arbiter
// PURPOSE
//  N-channel round-robin arbiter for the SDRAM bridge (ar_* side of sdram_contorller).
//  Generalises the single init-bridge path so the SoC init bridge, note-chart reader and audio fetch share one bridge.
//  Each channel is an addr/be/read/write master.
//  Exactly one transaction is in flight at a time; per-channel read data is registered.
// PARAMETERS
//  NUM_CH       2     number of requesting channels (1..8)
//  ADDR_W       26    bridge address width
//  DATA_W       16    bridge data width; BE_W = DATA_W/8 (localparam)
//  TIMEOUT_CYC  1024  BUSY cycles before abort (used only with ARB_TIMEOUT_EN)
//  CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1 (localparam)
// PORTS
//  Clk          in   1               system clock (MAX10_CLK1_50 domain)
//  Reset        in   1               synchronous, active-high
//  req_addr     in   NUM_CH*ADDR_W   channel i address at [i*ADDR_W +: ADDR_W]
//  req_be       in   NUM_CH*BE_W     per-channel byte enables
//  req_read     in   NUM_CH          read request, held until req_ac[i]
//  req_write    in   NUM_CH          write request, held until req_ac[i]
//  req_wrdata   in   NUM_CH*DATA_W   per-channel write data
//  req_ac       out  NUM_CH          one-cycle completion pulse
//  req_rddata   out  NUM_CH*DATA_W   per-channel registered read data
//  ar_addr      out  ADDR_W          to bridge_address
//  ar_be        out  BE_W            to bridge_byte_enable
//  ar_read      out  1               to bridge_read
//  ar_write     out  1               to bridge_write
//  ar_wrdata    out  DATA_W          to bridge_write_data
//  ar_ac        in   1               from bridge_acknowledge
//  ar_rddata    in   DATA_W          from bridge_read_data
//  busy         out  1               high in BUSY and DONE
//  grant_id     out  CH_W            channel currently or last granted
//  timeout_err  out  1               sticky timeout flag
// BEHAVIOUR
//  Reset: all outputs 0; rr pointer = NUM_CH-1 so ch0 has first priority; state IDLE.
//  Reset mid-transaction aborts immediately; no req_ac pulse is issued.
//  Request i is active when req_read[i] | req_write[i].
//  Read and write together count as a write; the read is ignored.
//  IDLE: if any request is active, grant the first active channel after the rr pointer (circular).
//   Same edge: latch addr/be/wrdata; assert ar_write or ar_read; set grant_id; set rr pointer = grant; enter BUSY.
//   Request in cycle N -> ar_read/ar_write high from N+1.
//  BUSY: ar_* held stable until the cycle ar_ac=1.
//   On that edge: ar_read/ar_write -> 0, ar_addr/ar_be/ar_wrdata hold, req_ac[grant] -> 1.
//   If the transaction was a read, req_rddata[grant] <= ar_rddata. Enter DONE.
//  DONE: req_ac[grant] is high for exactly this cycle; no arbitration here.
//   The requester drops its request on the DONE->IDLE edge. Next state IDLE.
//  Minimum transaction is 3 cycles (IDLE, BUSY with ar_ac, DONE); max throughput is 1 per 3 cycles.
//  ar_ac outside BUSY is ignored.
//  req_rddata of non-granted channels and of write transactions is unchanged.
//  No starvation: an active channel is served within NUM_CH transactions.
//  ar_read and ar_write are never high together.
//  req_ac is one-hot or zero.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   A BUSY cycle counter (width $clog2(TIMEOUT_CYC+1)) is cleared on BUSY entry.
//   When it reaches TIMEOUT_CYC with no ar_ac: drop ar_read/ar_write and pulse req_ac[grant] via DONE.
//   On a timed-out read, req_rddata[grant] = {DATA_W/16{16'hDEAD}}.
//   timeout_err is set to 1 and held until Reset.
//  ARB_TIMEOUT_EN undefined: BUSY waits for ar_ac indefinitely; timeout_err tied 0; no counter logic.
// TESTING
//  1 Read ch0 addr 0x0000100; ar_ac on 3rd BUSY cycle with ar_rddata 0xBEEF
//    -> ar_read high 3 cycles, req_ac[0] 1 cycle later, req_rddata ch0 = 0xBEEF.
//  2 NUM_CH=3, all channels hold requests after reset; ar_ac immediate
//    -> grants 0,1,2,0; each transaction 3 cycles; busy low only in IDLE cycles.
//  3 ch1 asserts req_read and req_write with wrdata 0x1234
//    -> ar_write=1, ar_read=0, ar_wrdata=0x1234; req_rddata ch1 unchanged.
//  4 Reset asserted on 2nd BUSY cycle
//    -> next cycle all outputs 0, no req_ac; after release, ch0 is granted first.
//  5 ARB_TIMEOUT_EN, TIMEOUT_CYC=16, read on ch0, ar_ac never
//    -> after 16 BUSY cycles req_ac[0] pulses, req_rddata ch0 = 0xDEAD, timeout_err=1 until Reset.
//    Without the macro: busy stays 1 and ar_read stays 1 for 100 cycles.
//  6 ch1 requests in the DONE cycle of ch0 -> ch1 is granted in the following IDLE cycle.
//    ch1's ar_write appears 1 cycle after that IDLE.

Source files
------------

// File: rtl/sdram_bridge_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_bridge_arbiter
// Description : N-channel round-robin arbiter in front of the SDRAM
//               controller bridge port. One transaction in flight at a time;
//               read data is captured per channel. Optional BUSY watchdog
//               enabled by defining ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_bridge_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 26,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*(DATA_W/8)-1:0] req_be,
    input  logic [NUM_CH-1:0]          req_read,
    input  logic [NUM_CH-1:0]          req_write,
    input  logic [NUM_CH*DATA_W-1:0]   req_wrdata,
    output logic [NUM_CH-1:0]          req_ac,
    output logic [NUM_CH*DATA_W-1:0]   req_rddata,
    output logic [ADDR_W-1:0]          ar_addr,
    output logic [DATA_W/8-1:0]        ar_be,
    output logic                       ar_read,
    output logic                       ar_write,
    output logic [DATA_W-1:0]          ar_wrdata,
    input  logic                       ar_ac,
    input  logic [DATA_W-1:0]          ar_rddata,
    output logic                       busy,
    output logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0] grant_id,
    output logic                       timeout_err
);

    localparam int BE_W = DATA_W/8;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    // Elaboration-time sanity check on the configuration.
    if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("sdram_bridge_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [NUM_CH-1:0]    w_active;
    logic                 w_found;
    logic [CH_W-1:0]      w_gnt;
    logic                 w_gnt_wr;
    logic [ADDR_W-1:0]    w_gnt_addr;
    logic [BE_W-1:0]      w_gnt_be;
    logic [DATA_W-1:0]    w_gnt_wd;
    logic                 w_tmo;
    logic [DATA_W-1:0]    w_rd_val;

    logic [CH_W-1:0]      r_ptr;
    logic [CH_W-1:0]      r_grant;
    logic [ADDR_W-1:0]    r_addr;
    logic [BE_W-1:0]      r_be;
    logic [DATA_W-1:0]    r_wrdata;
    logic                 r_read;
    logic                 r_write;
    logic [NUM_CH-1:0]    r_ac;
    logic [NUM_CH*DATA_W-1:0] r_rddata;

    // A write wins over a simultaneous read, but either makes the channel active.
    assign w_active = req_read | req_write;

    // Pick the first active channel strictly after the round-robin pointer.
    always_comb begin
        w_found    = 1'b0;
        w_gnt      = '0;
        w_gnt_wr   = 1'b0;
        w_gnt_addr = '0;
        w_gnt_be   = '0;
        w_gnt_wd   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_found && w_active[i] && (i == ((int'(r_ptr) + k) % NUM_CH))) begin
                    w_found    = 1'b1;
                    w_gnt      = CH_W'(i);
                    w_gnt_wr   = req_write[i];
                    w_gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
                    w_gnt_be   = req_be[i*BE_W +: BE_W];
                    w_gnt_wd   = req_wrdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DATA_W-1:0] c_TMO_DATA = {DATA_W/16{16'hDEAD}};

    logic [TCNT_W-1:0] r_tcnt;
    logic              r_terr;

    // Abort at the end of the TIMEOUT_CYC-th BUSY cycle unless the bridge acks.
    assign w_tmo    = (r_state == S_BUSY) && !ar_ac && (r_tcnt == TCNT_W'(TIMEOUT_CYC - 1));
    assign w_rd_val = w_tmo ? c_TMO_DATA : ar_rddata;

    // BUSY-cycle counter (held at zero outside BUSY) and sticky timeout flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_tcnt <= '0;
            r_terr <= 1'b0;
        end else begin
            if (r_state != S_BUSY) r_tcnt <= '0;
            else                   r_tcnt <= r_tcnt + 1'b1;
            if (w_tmo)             r_terr <= 1'b1;
        end
    end

    assign timeout_err = r_terr;
`else
    assign w_tmo       = 1'b0;
    assign w_rd_val    = ar_rddata;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic: grant from IDLE, complete on ack/timeout, one DONE cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_BUSY;
            S_BUSY:  if (ar_ac || w_tmo) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bridge-side command registers, completion pulse and per-channel read data.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ptr    <= CH_W'(NUM_CH - 1);
            r_grant  <= '0;
            r_addr   <= '0;
            r_be     <= '0;
            r_wrdata <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_ac     <= '0;
            r_rddata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ac <= '0;
                    if (w_found) begin
                        r_addr   <= w_gnt_addr;
                        r_be     <= w_gnt_be;
                        r_wrdata <= w_gnt_wd;
                        r_write  <= w_gnt_wr;
                        r_read   <= !w_gnt_wr;
                        r_grant  <= w_gnt;
                        r_ptr    <= w_gnt;
                    end
                end
                S_BUSY: begin
                    if (ar_ac || w_tmo) begin
                        r_read  <= 1'b0;
                        r_write <= 1'b0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (r_grant == CH_W'(i)) begin
                                r_ac[i] <= 1'b1;
                                if (r_read) r_rddata[i*DATA_W +: DATA_W] <= w_rd_val;
                            end
                        end
                    end
                end
                default: begin
                    r_ac <= '0;
                end
            endcase
        end
    end

    assign req_ac     = r_ac;
    assign req_rddata = r_rddata;
    assign ar_addr    = r_addr;
    assign ar_be      = r_be;
    assign ar_read    = r_read;
    assign ar_write   = r_write;
    assign ar_wrdata  = r_wrdata;
    assign busy       = (r_state != S_IDLE);
    assign grant_id   = r_grant;

endmodule
`default_nettype wire
